// File: rtl/overlay_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | overlay_pkg: shared sample-width default, channel id, sat counter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package overlay_pkg;

  localparam int c_DATA_W_DEF = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iq_sample_fifo: per-channel IQ buffer, wrap-bit full/empty          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module iq_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/iq_channel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iq_channel_arbiter: two IQ channels round-robin onto one datapath   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module iq_channel_arbiter
  import overlay_pkg::*;
#(
  parameter int DATA_W     = c_DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_ch0_I,
  input  logic [DATA_W-1:0] i_ch0_Q,
  input  logic [DATA_W-1:0] i_ch1_I,
  input  logic [DATA_W-1:0] i_ch1_Q,
  input  logic              i_ch0_valid,
  input  logic              i_ch1_valid,
  input  logic              i_ch0_en,
  input  logic              i_ch1_en,
  output logic [DATA_W-1:0] o_I,
  output logic [DATA_W-1:0] o_Q,
  output logic              o_chan,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_ch0_drops,
  output logic [7:0]        o_ch1_drops,
  input  logic              i_clr
);

  localparam int c_WW = 2 * DATA_W;

  logic [1:0]      w_req, w_push, w_pop, w_drop, w_full, w_empty;
  logic [c_WW-1:0] w_in_data   [2];
  logic [c_WW-1:0] w_fifo_data [2];
  logic [c_WW-1:0] w_sel_data;
  logic [7:0]      r_drops [2];
  logic            w_xfer, w_load, w_any;
  chan_e           w_grant;
  chan_e           r_last;
  logic            r_valid;
  logic            r_chan;
  logic [DATA_W-1:0] r_I, r_Q;

  assign w_req[0]     = i_ch0_valid & i_ch0_en;
  assign w_req[1]     = i_ch1_valid & i_ch1_en;
  assign w_in_data[0] = {i_ch0_I, i_ch0_Q};
  assign w_in_data[1] = {i_ch1_I, i_ch1_Q};

  assign w_xfer = r_valid & i_ready;
  assign w_load = ~r_valid | w_xfer;
  assign w_any  = ~(&w_empty);

  // On a tie the channel not served last wins.
  always_comb begin
    w_grant = CH0;
    if (!w_empty[0] && !w_empty[1])
      w_grant = (r_last == CH1) ? CH0 : CH1;
    else if (!w_empty[1])
      w_grant = CH1;
  end

  assign w_pop[0]   = w_load & ~w_empty[0] & (w_grant == CH0);
  assign w_pop[1]   = w_load & ~w_empty[1] & (w_grant == CH1);
  assign w_sel_data = (w_grant == CH1) ? w_fifo_data[1] : w_fifo_data[0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    // A full FIFO still accepts when the same cycle frees a slot.
    assign w_push[gi] = w_req[gi] & (~w_full[gi] | w_pop[gi]);
    assign w_drop[gi] = w_req[gi] & w_full[gi] & ~w_pop[gi];

    iq_sample_fifo #(
      .WIDTH (c_WW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_data  (w_in_data[gi]),
      .o_data  (w_fifo_data[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)         r_drops[gi] <= 8'd0;
      else if (i_clr)       r_drops[gi] <= 8'd0;
      else if (w_drop[gi])  r_drops[gi] <= sat_inc8(r_drops[gi]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_I     <= '0;
      r_Q     <= '0;
      r_chan  <= 1'b0;
      r_last  <= CH1;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_I    <= w_sel_data[c_WW-1:DATA_W];
        r_Q    <= w_sel_data[DATA_W-1:0];
        r_chan <= w_grant;
        r_last <= w_grant;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_I         = r_I;
  assign o_Q         = r_Q;
  assign o_chan      = r_chan;
  assign o_ch0_drops = r_drops[0];
  assign o_ch1_drops = r_drops[1];

endmodule
`default_nettype wire

// File: tb/tb_iq_channel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_iq_channel_arbiter: randomized stimulus vs queue reference model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_iq_channel_arbiter;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ch0_I = '0, ch0_Q = '0, ch1_I = '0, ch1_Q = '0;
  logic          ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic          ch0_en = 1'b1, ch1_en = 1'b1;
  logic          ready = 1'b0, clr = 1'b0;
  logic [DW-1:0] o_I, o_Q;
  logic          o_chan, o_valid;
  logic [7:0]    o_ch0_drops, o_ch1_drops;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2*DW-1:0] q0[$];
  logic [2*DW-1:0] q1[$];
  bit              m_valid;
  bit              m_chan;
  bit              m_last;
  logic [DW-1:0]   m_I, m_Q;
  int              m_d0, m_d1;

  iq_channel_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ch0_I(ch0_I), .i_ch0_Q(ch0_Q), .i_ch1_I(ch1_I), .i_ch1_Q(ch1_Q),
    .i_ch0_valid(ch0_valid), .i_ch1_valid(ch1_valid),
    .i_ch0_en(ch0_en), .i_ch1_en(ch1_en),
    .o_I(o_I), .o_Q(o_Q), .o_chan(o_chan), .o_valid(o_valid),
    .i_ready(ready),
    .o_ch0_drops(o_ch0_drops), .o_ch1_drops(o_ch1_drops),
    .i_clr(clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_valid = 0; m_chan = 0; m_last = 1; m_I = '0; m_Q = '0;
    m_d0 = 0; m_d1 = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  task automatic model_edge();
    bit load; int g; logic [2*DW-1:0] w;
    load = !m_valid || ready;
    g = -1;
    if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
    else if (q0.size() > 0) g = 0;
    else if (q1.size() > 0) g = 1;
    w = '0;
    if (load && g == 0) w = q0.pop_front();
    if (load && g == 1) w = q1.pop_front();
    if (ch0_valid && ch0_en) begin
      if (q0.size() < DEPTH) q0.push_back({ch0_I, ch0_Q});
      else if (m_d0 < 255) m_d0++;
    end
    if (ch1_valid && ch1_en) begin
      if (q1.size() < DEPTH) q1.push_back({ch1_I, ch1_Q});
      else if (m_d1 < 255) m_d1++;
    end
    if (clr) begin m_d0 = 0; m_d1 = 0; end
    if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_chan = g[0]; m_last = g[0]; {m_I, m_Q} = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    ch0_valid = 0; ch1_valid = 0; ch0_en = 1; ch1_en = 1; ready = 0; clr = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic rand_samples();
    ch0_I = 16'($urandom); ch0_Q = 16'($urandom);
    ch1_I = 16'($urandom); ch1_Q = 16'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o_valid, o_I, o_Q, o_chan, o_ch0_drops, o_ch1_drops} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b I=%h Q=%h c=%0b d0=%0d d1=%0d, want all zero",
               o_valid, o_I, o_Q, o_chan, o_ch0_drops, o_ch1_drops);
    end
  endtask

  task automatic test_single();
    do_reset();
    ready = 1; ch0_I = 16'h0010; ch0_Q = 16'hFFF0; ch0_valid = 1;
    tick();
    ch0_valid = 0;
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early: o_valid=%0b want 0", o_valid);
    end
    tick();
    n_tests++;
    if ({o_valid, o_chan, o_I, o_Q} !== {1'b1, 1'b0, 16'h0010, 16'hFFF0}) begin
      n_fail++;
      $display("FAIL single_out: got v=%0b c=%0b I=%h Q=%h want v=1 c=0 I=0010 Q=fff0",
               o_valid, o_chan, o_I, o_Q);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: o_valid=%0b want 0", o_valid);
    end
  endtask

  task automatic test_alternate();
    bit prev; int outs;
    do_reset();
    ready = 1; outs = 0; prev = 1;
    for (int i = 0; i < 12; i++) begin
      rand_samples();
      ch0_valid = (i < 8); ch1_valid = (i < 8);
      tick();
      n_tests++;
      if (o_valid !== m_valid || (m_valid && {o_chan, o_I, o_Q} !== {m_chan, m_I, m_Q})) begin
        n_fail++;
        $display("FAIL alt_out[%0d]: got v=%0b c=%0b I=%h Q=%h want v=%0b c=%0b I=%h Q=%h",
                 i, o_valid, o_chan, o_I, o_Q, m_valid, m_chan, m_I, m_Q);
      end
      if (o_valid) begin
        n_tests++;
        if (o_chan === prev) begin
          n_fail++; $display("FAIL alt_chan[%0d]: o_chan=%0b repeated, want %0b", i, o_chan, !prev);
        end
        prev = o_chan; outs++;
      end
    end
    ch0_valid = 0; ch1_valid = 0;
    n_tests++;
    if (outs != 11) begin
      n_fail++; $display("FAIL alt_count: got %0d outputs want 11", outs);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_I, held_Q;
    do_reset();
    ready = 0;
    for (int i = 0; i < 6; i++) begin
      rand_samples(); ch0_valid = 1;
      tick();
      if (i == 1) begin held_I = o_I; held_Q = o_Q; end
      if (i >= 1) begin
        n_tests++;
        if ({o_valid, o_chan, o_I, o_Q} !== {1'b1, 1'b0, held_I, held_Q} ||
            {o_I, o_Q} !== {m_I, m_Q}) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got v=%0b c=%0b I=%h Q=%h want v=1 c=0 I=%h Q=%h",
                   i, o_valid, o_chan, o_I, o_Q, m_I, m_Q);
        end
      end
    end
    ch0_valid = 0;
    n_tests++;
    if (o_ch0_drops !== 8'd1 || q0.size() != 4) begin
      n_fail++; $display("FAIL bp_drops: got %0d want 1 (model buf %0d)", o_ch0_drops, q0.size());
    end
    ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (o_valid !== m_valid || (m_valid && {o_chan, o_I, o_Q} !== {m_chan, m_I, m_Q})) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v=%0b I=%h Q=%h want v=%0b I=%h Q=%h",
                 i, o_valid, o_I, o_Q, m_valid, m_I, m_Q);
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    ready = 1; ch1_en = 0;
    for (int i = 0; i < 20; i++) begin
      rand_samples(); ch0_valid = $urandom_range(0, 1); ch1_valid = 1;
      tick();
      n_tests++;
      if ((o_valid && o_chan) || o_valid !== m_valid || o_ch1_drops !== 8'd0) begin
        n_fail++;
        $display("FAIL dis[%0d]: got v=%0b c=%0b d1=%0d want v=%0b c=0 d1=0",
                 i, o_valid, o_chan, o_ch1_drops, m_valid);
      end
    end
    ch0_valid = 0; ch1_valid = 0; ch1_en = 1;
  endtask

  task automatic test_saturate();
    do_reset();
    ready = 0; ch0_valid = 1;
    repeat (260) begin rand_samples(); tick(); end
    n_tests++;
    if (o_ch0_drops !== 8'd255 || m_d0 != 255) begin
      n_fail++; $display("FAIL sat_255: got %0d want 255", o_ch0_drops);
    end
    repeat (3) tick();
    n_tests++;
    if (o_ch0_drops !== 8'd255) begin
      n_fail++; $display("FAIL sat_hold: got %0d want 255", o_ch0_drops);
    end
    clr = 1;
    tick();
    clr = 0; ch0_valid = 0;
    n_tests++;
    if (o_ch0_drops !== 8'd0 || m_d0 != 0) begin
      n_fail++; $display("FAIL sat_clr: got %0d want 0", o_ch0_drops);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    ready = 0;
    repeat (4) begin rand_samples(); ch0_valid = 1; tick(); end
    ch0_valid = 0;
    ready = 1;
    tick();
    rst_n = 0;
    #1;
    model_reset();
    n_tests++;
    if (o_valid !== 1'b0 || o_ch0_drops !== 8'd0) begin
      n_fail++; $display("FAIL mid_rst: got v=%0b d0=%0d want v=0 d0=0", o_valid, o_ch0_drops);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (o_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: o_valid=%0b want 0", i, o_valid);
      end
    end
    rand_samples(); ch1_valid = 1;
    tick(); ch1_valid = 0;
    tick();
    n_tests++;
    if ({o_valid, o_chan, o_I, o_Q} !== {1'b1, 1'b1, m_I, m_Q}) begin
      n_fail++;
      $display("FAIL mid_new: got v=%0b c=%0b I=%h Q=%h want v=1 c=1 I=%h Q=%h",
               o_valid, o_chan, o_I, o_Q, m_I, m_Q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_samples();
      ch0_valid = $urandom_range(0, 1);
      ch1_valid = $urandom_range(0, 1);
      ch0_en    = ($urandom_range(0, 7) != 0);
      ch1_en    = ($urandom_range(0, 7) != 0);
      ready     = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      tick();
      n_tests++;
      if (o_valid !== m_valid || (m_valid && {o_chan, o_I, o_Q} !== {m_chan, m_I, m_Q}) ||
          o_ch0_drops !== 8'(m_d0) || o_ch1_drops !== 8'(m_d1)) begin
        n_fail++;
        $display("FAIL rand[%0d]: got v=%0b c=%0b I=%h Q=%h d=%0d/%0d want v=%0b c=%0b I=%h Q=%h d=%0d/%0d",
                 i, o_valid, o_chan, o_I, o_Q, o_ch0_drops, o_ch1_drops,
                 m_valid, m_chan, m_I, m_Q, m_d0, m_d1);
      end
    end
    ch0_valid = 0; ch1_valid = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_disable();
    test_saturate();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
